// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like bus bridge.
// State encoding and access-size codes.
package sram_like_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        DRAIN
    } stateT;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

endpackage

// File: rtl/sram_like_bridge.sv
// Adapter from the core's single-cycle SRAM port to an SRAM-like
// req/addr_ok/data_ok bus, with flush draining and a watchdog.
module sram_like_bridge
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_en,
    input  logic [DATA_W/8-1:0] core_wen,
    input  logic [1:0]          core_size,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic                core_flush,
    input  logic                core_pipe_stall,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_stall,
    output logic                req,
    output logic                wr,
    output logic [1:0]          size,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                bus_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    stateT           state;
    logic            cancel;
    logic [CW-1:0]   wdCnt;
    logic            accept;
    logic            dropNow;

    assign accept  = core_en && !core_flush;
    assign dropNow = cancel || core_flush;

    assign core_stall = !rst && (
        (state == IDLE && accept) ||
        state == ADDR ||
        state == DATA ||
        state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cancel     <= 1'b0;
            req        <= 1'b0;
            wr         <= 1'b0;
            size       <= '0;
            wstrb      <= '0;
            addr       <= '0;
            wdata      <= '0;
            core_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= ADDR;
                        req    <= 1'b1;
                        wr     <= |core_wen;
                        size   <= core_size;
                        wstrb  <= core_wen;
                        addr   <= core_addr;
                        wdata  <= core_wdata;
                        cancel <= 1'b0;
                    end
                end
                ADDR: begin
                    if (core_flush) cancel <= 1'b1;
                    if (addr_ok) begin
                        req <= 1'b0;
                        if (data_ok && dropNow) begin
                            state  <= IDLE;
                            cancel <= 1'b0;
                        end else if (data_ok) begin
                            state <= HOLD;
                            if (!wr) core_rdata <= rdata;
                        end else begin
                            state <= dropNow ? DRAIN : DATA;
                        end
                    end
                end
                DATA: begin
                    // A response arriving with the flush completes the drain.
                    if (core_flush) begin
                        state <= data_ok ? IDLE : DRAIN;
                    end else if (data_ok) begin
                        state <= HOLD;
                        if (!wr) core_rdata <= rdata;
                    end
                end
                HOLD: begin
                    if (core_flush || !core_pipe_stall) state <= IDLE;
                end
                DRAIN: begin
                    if (data_ok) begin
                        state  <= IDLE;
                        cancel <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Watchdog observes only; it never alters the transfer FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCnt   <= '0;
            bus_err <= 1'b0;
        end else if (TIMEOUT != 0) begin
            if (state == IDLE) begin
                if (accept) wdCnt <= '0;
            end else if (state != HOLD && wdCnt != CW'(TIMEOUT)) begin
                wdCnt <= wdCnt + 1'b1;
                if (wdCnt + 1'b1 == CW'(TIMEOUT)) bus_err <= 1'b1;
            end
        end
    end

    stray_data_ok : assert property (@(posedge clk) disable iff (rst)
        !(data_ok && (state == IDLE || state == HOLD)));

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed plus randomized checks of sram_like_bridge against a
// transaction-level model of expected stalls and returned data.
module tb_sram_like_bridge;
    import sram_like_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_en;
    logic [3:0]    core_wen;
    logic [1:0]    core_size;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_flush;
    logic          core_pipe_stall;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [DW-1:0] rdata;
    logic          bus_err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] expRd;

    sram_like_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_wen(core_wen),
        .core_size(core_size), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_flush(core_flush),
        .core_pipe_stall(core_pipe_stall),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: aw wait cycles before addr_ok, response dw
    // cycles after it (0 = same cycle), then hold cycles of pipe stall.
    task automatic xfer(input logic [3:0] wen, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int aw,
                        input int dw, input int hold);
        int   stalls;
        logic isW;
        stalls = 0;
        isW = |wen;
        @(negedge clk);
        core_en = 1; core_wen = wen; core_size = sz;
        core_addr = a; core_wdata = wd;
        core_flush = 0; core_pipe_stall = 0;
        addr_ok = 0; data_ok = 0;
        #1;
        chk("acceptStall", core_stall, 1);
        chk("idleReq", req, 0);
        if (core_stall) stalls++;
        for (int i = 0; i <= aw; i++) begin
            @(negedge clk);
            addr_ok = (i == aw);
            data_ok = (i == aw && dw == 0);
            rdata = rd;
            #1;
            chk("req", req, 1);
            chk("wr", wr, isW);
            chk("addr", addr, a);
            chk("wstrb", wstrb, wen);
            chk("size", size, sz);
            chk("wdata", wdata, wd);
            if (core_stall) stalls++;
        end
        for (int j = 1; j <= dw; j++) begin
            @(negedge clk);
            addr_ok = 0;
            data_ok = (j == dw);
            rdata = (j == dw) ? rd : $urandom;
            #1;
            chk("dataReq", req, 0);
            if (core_stall) stalls++;
        end
        if (!isW) expRd = rd;
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            core_en = 0; addr_ok = 0; data_ok = 0;
            core_pipe_stall = (k < hold);
            #1;
            chk("holdRdata", core_rdata, expRd);
            chk("holdStall", core_stall, 0);
        end
        chk("stallCycles", stalls, 2 + aw + dw);
        chk("busErrQuiet", bus_err, 0);
    endtask

    initial begin
        rst = 1; core_en = 1; core_wen = 0; core_size = 0;
        core_addr = 0; core_wdata = 0; core_flush = 0;
        core_pipe_stall = 0; addr_ok = 0; data_ok = 0; rdata = 0;
        expRd = 0;
        #1;
        chk("rstStall", core_stall, 0);
        chk("rstReq", req, 0);
        chk("rstRdata", core_rdata, 0);
        chk("rstAddr", addr, 0);
        chk("rstBusErr", bus_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0; core_en = 0;
        #1;
        chk("postRstStall", core_stall, 0);

        xfer(4'b0000, SZ_WORD, 32'h1000_0000, 32'h0,
             32'hDEAD_BEEF, 0, 1, 0);
        xfer(4'b0011, SZ_HALF, 32'h8000_1000, 32'h1234_5678,
             32'h5A5A_5A5A, 3, 1, 0);
        xfer(4'b0000, SZ_WORD, 32'h2000_0040, 32'h0,
             32'hCAFE_F00D, 0, 0, 5);

        // flush while waiting for the response
        @(negedge clk);
        core_en = 1; core_wen = 0; core_addr = 32'h3000_0000;
        #1;
        chk("fdAccept", core_stall, 1);
        @(negedge clk);
        addr_ok = 1;
        #1;
        chk("fdReq", req, 1);
        @(negedge clk);
        addr_ok = 0; core_flush = 1;
        #1;
        chk("fdDataStall", core_stall, 1);
        @(negedge clk);
        core_flush = 0; data_ok = 1; rdata = 32'hAAAA_5555;
        core_addr = 32'h3000_0100;
        #1;
        chk("fdDrainReq", req, 0);
        chk("fdDrainStall", core_stall, 1);
        @(negedge clk);
        data_ok = 0;
        #1;
        chk("fdKeepRdata", core_rdata, expRd);
        chk("fdIdleReq", req, 0);
        chk("fdIdleStall", core_stall, 1);
        @(negedge clk);
        addr_ok = 1; data_ok = 1; rdata = 32'h0BAD_CAFE;
        #1;
        chk("fdNewReq", req, 1);
        chk("fdNewAddr", addr, 32'h3000_0100);
        @(negedge clk);
        addr_ok = 0; data_ok = 0; core_en = 0;
        expRd = 32'h0BAD_CAFE;
        #1;
        chk("fdNewRdata", core_rdata, expRd);
        chk("fdNewStall", core_stall, 0);

        // flush alongside a request in IDLE issues nothing
        @(negedge clk);
        core_en = 1; core_flush = 1;
        #1;
        chk("fiStall", core_stall, 0);
        @(negedge clk);
        core_en = 0; core_flush = 0;
        #1;
        chk("fiReq", req, 0);
        chk("fiStall2", core_stall, 0);

        // flush while the request is still pending
        @(negedge clk);
        core_en = 1; core_addr = 32'h4000_0000;
        @(negedge clk);
        core_en = 0; core_flush = 1;
        #1;
        chk("faReqKept", req, 1);
        @(negedge clk);
        core_flush = 0; addr_ok = 1;
        #1;
        chk("faReqAck", req, 1);
        chk("faStall", core_stall, 1);
        @(negedge clk);
        addr_ok = 0;
        #1;
        chk("faDrainReq", req, 0);
        chk("faDrainStall", core_stall, 1);
        @(negedge clk);
        data_ok = 1; rdata = $urandom;
        #1;
        chk("faDrainStall2", core_stall, 1);
        @(negedge clk);
        data_ok = 0;
        #1;
        chk("faIdleStall", core_stall, 0);
        chk("faRdata", core_rdata, expRd);

        // flush in HOLD returns to IDLE despite pipe stall
        @(negedge clk);
        core_en = 1; core_addr = 32'h5000_0000;
        @(negedge clk);
        addr_ok = 1; data_ok = 1; rdata = 32'h1357_9BDF;
        @(negedge clk);
        addr_ok = 0; data_ok = 0; core_en = 0;
        core_pipe_stall = 1; core_flush = 1;
        expRd = 32'h1357_9BDF;
        #1;
        chk("fhHoldStall", core_stall, 0);
        @(negedge clk);
        core_flush = 0; core_en = 1; core_addr = 32'h5000_0010;
        #1;
        chk("fhIdleStall", core_stall, 1);
        @(negedge clk);
        core_pipe_stall = 0; addr_ok = 1; data_ok = 1;
        rdata = 32'h2468_ACE0;
        #1;
        chk("fhReq", req, 1);
        @(negedge clk);
        addr_ok = 0; data_ok = 0; core_en = 0;
        expRd = 32'h2468_ACE0;
        #1;
        chk("fhRdata", core_rdata, expRd);

        for (int n = 0; n < 20; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) != 0)
                ? 4'($urandom_range(1, 15)) : 4'h0;
            xfer(w, 2'($urandom_range(0, 2)), $urandom, $urandom,
                 $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // watchdog: addr_ok withheld
        @(negedge clk);
        core_en = 1; core_wen = 0; core_addr = 32'h6000_0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            #1;
            chk("wdReq", req, 1);
            chk("wdBusErr", bus_err, k >= 9);
        end
        @(negedge clk);
        addr_ok = 1; data_ok = 1; rdata = 32'h7777_0001;
        @(negedge clk);
        addr_ok = 0; data_ok = 0; core_en = 0;
        expRd = 32'h7777_0001;
        #1;
        chk("wdRdata", core_rdata, expRd);
        chk("wdSticky", bus_err, 1);
        @(negedge clk);
        #1;
        chk("wdStickyIdle", bus_err, 1);

        // reset mid-request
        @(negedge clk);
        core_en = 1; core_addr = 32'h7000_0000;
        @(negedge clk);
        #1;
        chk("rmReq", req, 1);
        rst = 1;
        #1;
        chk("rmReqClr", req, 0);
        chk("rmStall", core_stall, 0);
        chk("rmBusErr", bus_err, 0);
        chk("rmRdata", core_rdata, 0);
        chk("rmAddr", addr, 0);
        @(negedge clk);
        rst = 0; core_en = 0;
        #1;
        chk("rmIdleReq", req, 0);
        chk("rmIdleStall", core_stall, 0);
        @(negedge clk);
        core_en = 1;
        #1;
        chk("rmAcceptStall", core_stall, 1);
        @(negedge clk);
        core_en = 0;
        #1;
        chk("rmAcceptReq", req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
